text_fetch_sequencer: RTL and testbench

Per-scanline fetch controller for the VGA text-mode pixel path. For each character cell on a scanline it reads the character code and colour attribute from text RAM, then the matching glyph line from font ROM. It presents font line, attribute and pixel column to the pixel-to-colour-index datapath one pixel per clock. Two-deep cell buffering overlaps the fetch of cell n+1 with the display of cell n, so pixels stream with no gaps across a full text line.

---
 rtl/text_fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_text_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/text_fetch_sequencer.sv
// Per-scanline text-mode fetch controller: text RAM -> font ROM -> pixel stream.
// A next-cell buffer is filled during pixels 4..6 of the current cell so cells stream back to back.
module text_fetch_sequencer #(
   parameter int COLS   = 80,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_start,
   input  logic [4:0]        char_row,
   input  logic [3:0]        font_row,
   output logic              text_rd,
   output logic [ADDR_W-1:0] text_addr,
   input  logic [15:0]       text_data,
   output logic              font_rd,
   output logic [11:0]       font_addr,
   input  logic [7:0]        font_data,
   output logic              pix_valid,
   output logic [7:0]        font_line_data,
   output logic [7:0]        bg_fg_index,
   output logic [2:0]        char_pix_x,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_pf_cnt;
   logic [ADDR_W-1:0] r_base;
   logic [3:0]        r_font_row;
   logic [7:0]        r_col;
   logic [7:0]        r_attr_pipe;
   logic [7:0]        r_next_glyph;
   logic [7:0]        r_next_attr;

   logic [31:0]       w_base_full;
   logic [ADDR_W-1:0] w_base;
   logic              w_last_col;
   logic              w_more_cols;

   assign w_base_full = 32'(char_row) * COLS;
   assign w_base      = w_base_full[ADDR_W-1:0];
   assign w_last_col  = (r_col == 8'(COLS - 1));
   assign w_more_cols = ((r_col + 8'd1) < 8'(COLS));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (line_start) w_state_next = PREFETCH;
         PREFETCH: if (r_pf_cnt == 2'd2) w_state_next = RUN;
         RUN:      if (char_pix_x == 3'd7 && w_last_col) w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_pf_cnt       <= 2'd0;
         r_base         <= '0;
         r_font_row     <= 4'd0;
         r_col          <= 8'd0;
         r_attr_pipe    <= 8'd0;
         r_next_glyph   <= 8'd0;
         r_next_attr    <= 8'd0;
         text_rd        <= 1'b0;
         text_addr      <= '0;
         font_rd        <= 1'b0;
         font_addr      <= 12'd0;
         pix_valid      <= 1'b0;
         font_line_data <= 8'd0;
         bg_fg_index    <= 8'd0;
         char_pix_x     <= 3'd0;
         busy           <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         busy      <= (w_state_next != IDLE);
         pix_valid <= (w_state_next == RUN);
         text_rd   <= 1'b0;
         font_rd   <= 1'b0;

         if (r_state == IDLE && line_start) begin
            r_font_row <= font_row;
            r_base     <= w_base;
            r_col      <= 8'd0;
            r_pf_cnt   <= 2'd0;
            text_rd    <= 1'b1;
            text_addr  <= w_base;
         end
         if (r_state == PREFETCH) r_pf_cnt <= r_pf_cnt + 2'd1;

         // Registered strobe shows at char_pix_x==4, so decide one pixel early.
         if (r_state == RUN && char_pix_x == 3'd3 && w_more_cols) begin
            text_rd   <= 1'b1;
            text_addr <= r_base + ADDR_W'(r_col) + ADDR_W'(1);
         end

         // Text word -> font request; attribute rides one stage alongside it.
         if (text_rd) begin
            font_rd     <= 1'b1;
            font_addr   <= {text_data[7:0], r_font_row};
            r_attr_pipe <= text_data[15:8];
         end
         if (font_rd) begin
            r_next_glyph <= font_data;
            r_next_attr  <= r_attr_pipe;
         end

         if (w_state_next == RUN && (r_state == PREFETCH || char_pix_x == 3'd7)) begin
            font_line_data <= r_next_glyph;
            bg_fg_index    <= r_next_attr;
            char_pix_x     <= 3'd0;
            if (r_state == RUN) r_col <= r_col + 8'd1;
         end else if (w_state_next == RUN) begin
            char_pix_x <= char_pix_x + 3'd1;
         end else begin
            font_line_data <= 8'd0;
            bg_fg_index    <= 8'd0;
            char_pix_x     <= 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_text_fetch_sequencer.sv
// Randomized scoreboard bench for text_fetch_sequencer with memory models for text RAM and font ROM.
module tb_text_fetch_sequencer;

   localparam int COLS   = 80;
   localparam int ADDR_W = 12;

   logic              clk;
   logic              rst_n;
   logic              line_start;
   logic [4:0]        char_row;
   logic [3:0]        font_row;
   logic              text_rd;
   logic [ADDR_W-1:0] text_addr;
   logic [15:0]       text_data;
   logic              font_rd;
   logic [11:0]       font_addr;
   logic [7:0]        font_data;
   logic              pix_valid;
   logic [7:0]        font_line_data;
   logic [7:0]        bg_fg_index;
   logic [2:0]        char_pix_x;
   logic              busy;

   text_fetch_sequencer #(.COLS(COLS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .line_start(line_start), .char_row(char_row),
      .font_row(font_row), .text_rd(text_rd), .text_addr(text_addr),
      .text_data(text_data), .font_rd(font_rd), .font_addr(font_addr),
      .font_data(font_data), .pix_valid(pix_valid), .font_line_data(font_line_data),
      .bg_fg_index(bg_fg_index), .char_pix_x(char_pix_x), .busy(busy)
   );

   logic [15:0] tmem [0:4095];
   logic [7:0]  from [0:4095];

   logic [18:0] exp_pix[$];
   logic [11:0] exp_ta[$];
   logic [11:0] exp_fa[$];
   int          exp_start[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          run_len = 0;
   logic        pv_d = 1'b0;
   logic [11:0] last_ta = 12'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Memories answer one cycle after the strobe; garbage otherwise.
   always @(posedge clk) begin
      #1;
      text_data = text_rd ? tmem[text_addr] : 16'($urandom);
      font_data = font_rd ? from[font_addr] : 8'($urandom);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: pops expectations whenever the DUT presents a strobe or pixel.
   always @(negedge clk) begin
      if (!rst_n) begin
         run_len = 0;
         pv_d    = 1'b0;
      end else begin
         if (text_rd) begin
            if (exp_ta.size() == 0) check("text_rd_expected", 32'(exp_ta.size()), 32'd1);
            else check("text_addr", 32'(text_addr), 32'(exp_ta.pop_front()));
            last_ta = text_addr;
         end
         if (font_rd) begin
            if (exp_fa.size() == 0) check("font_rd_expected", 32'(exp_fa.size()), 32'd1);
            else check("font_addr", 32'(font_addr), 32'(exp_fa.pop_front()));
         end
         if (pix_valid) begin
            if (!pv_d) begin
               if (exp_start.size() == 0) check("pix_start_expected", 32'(exp_start.size()), 32'd1);
               else check("pix_start_cycle", 32'(cyc), 32'(exp_start.pop_front()));
            end
            run_len++;
            if (exp_pix.size() == 0) check("pix_expected", 32'(exp_pix.size()), 32'd1);
            else check("pixel{glyph,attr,x}", 32'({font_line_data, bg_fg_index, char_pix_x}),
                       32'(exp_pix.pop_front()));
         end else begin
            check("idle_pix_outputs_zero", 32'({font_line_data, bg_fg_index, char_pix_x}), 32'd0);
            if (pv_d) begin
               check("pix_run_len", 32'(run_len), 32'(COLS * 8));
               check("busy_falls_with_pix", 32'(busy), 32'd0);
               run_len = 0;
            end
         end
         pv_d = pix_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_line(input logic [4:0] r, input logic [3:0] f);
      int base;
      logic [15:0] w;
      logic [11:0] fa;
      base = (int'(r) * COLS) % 4096;
      for (int c = 0; c < COLS; c++) begin
         w  = tmem[(base + c) % 4096];
         fa = {w[7:0], f};
         exp_ta.push_back(12'((base + c) % 4096));
         exp_fa.push_back(fa);
         for (int x = 0; x < 8; x++) exp_pix.push_back({from[fa], w[15:8], 3'(x)});
      end
      exp_start.push_back(cyc + 4);
      char_row   = r;
      font_row   = f;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("first_text_addr", 32'(text_addr), 32'(base));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && busy; i++) tick();
      check("line_completes", 32'(busy), 32'd0);
      check("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
      check("text_queue_drained", 32'(exp_ta.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         tmem[i] = 16'($urandom);
         from[i] = 8'($urandom);
      end
      tmem[160] = 16'hA141;
      tmem[161] = 16'h1F42;
      tmem[162] = 16'h0743;
      tmem[163] = 16'hE044;
      from[12'h415] = 8'h81;
      text_data  = 16'd0;
      font_data  = 8'd0;
      rst_n      = 1'b0;
      line_start = 1'b1;
      char_row   = 5'd3;
      font_row   = 4'd1;

      // Reset dominates line_start.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_outputs", 32'({text_rd, font_rd, pix_valid, busy, text_addr, font_addr}), 32'd0);
         check("reset_pixel", 32'({font_line_data, bg_fg_index, char_pix_x}), 32'd0);
      end
      line_start = 1'b0;
      rst_n      = 1'b1;
      tick();

      // Known row: base 160, chars 0x41..0x44, glyph 0x81 on char 0x41 row 5.
      start_line(5'd2, 4'd5);
      wait_idle();

      // A second line_start during RUN is ignored; the next one after busy falls is taken.
      start_line(5'd7, 4'd3);
      repeat (9) tick();
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      wait_idle();
      start_line(5'd8, 4'd9);
      wait_idle();

      // Reset mid-line aborts immediately.
      start_line(5'd10, 4'd7);
      repeat (14) tick();
      rst_n = 1'b0;
      tick();
      check("abort_pix_valid", 32'(pix_valid), 32'd0);
      check("abort_text_rd", 32'(text_rd), 32'd0);
      check("abort_font_rd", 32'(font_rd), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      exp_pix.delete();
      exp_ta.delete();
      exp_fa.delete();
      exp_start.delete();
      rst_n = 1'b1;
      tick();
      start_line(5'd10, 4'd7);
      wait_idle();

      // Last row of a 30-row screen.
      start_line(5'd29, 4'hF);
      wait_idle();
      check("last_text_addr", 32'(last_ta), 32'd2399);

      for (int n = 0; n < 3; n++) begin
         start_line(5'($urandom_range(0, 29)), 4'($urandom_range(0, 15)));
         wait_idle();
      end

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
